// File: rtl/pe_acc_pkg.sv
// Shared types and constants for the PE shift accumulator.
// Holds the FSM state encoding, default widths and the precision-mode-to-term-count table.
package pe_acc_pkg;

    localparam int unsigned DEF_IN_W  = 20;
    localparam int unsigned DEF_ACC_W = 24;
    localparam int unsigned DEF_CNT_W = 5;

    // Terms per group for each operand precision (2b x 2b ... 8b x 8b)
    localparam int unsigned TERMS_2B = 1;
    localparam int unsigned TERMS_4B = 4;
    localparam int unsigned TERMS_6B = 9;
    localparam int unsigned TERMS_8B = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/pe_acc_add.sv
// Signed W-bit adder for the accumulator.
// Build option: PE_ACC_SAT_EN clamps the result to the signed W-bit range;
// without it the sum wraps modulo 2^W.
// Ports: a, b - signed addends; sum - signed result.
module pe_acc_add #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] raw;

    assign raw = a + b;

`ifdef PE_ACC_SAT_EN
    logic ovf_pos;
    logic ovf_neg;

    // Overflow only possible when both addends share a sign that the result lost
    assign ovf_pos = !a[W-1] && !b[W-1] &&  raw[W-1];
    assign ovf_neg =  a[W-1] &&  b[W-1] && !raw[W-1];

    always_comb begin
        sum = raw;
        if (ovf_pos) begin
            sum = {1'b0, {(W-1){1'b1}}};
        end else if (ovf_neg) begin
            sum = {1'b1, {(W-1){1'b0}}};
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/pe_shift_accumulator.sv
// Accumulates a configurable number of sign-extended, shifted PE partial sums
// into one dot-product result and holds it until the column adder takes it.
// Build option: PE_ACC_SAT_EN (saturating adds, handled in pe_acc_add).
// Ports:
//   clk, reset (async, active-low), clear (sync abort)
//   cfg_terms  - terms per group, sampled on the first beat, 0 treated as 1
//   in_valid/in_ready/in_data    - upstream beat handshake (in_ready is combinational)
//   out_valid/out_ready/out_data - downstream result handshake
//   busy       - group in progress or result held
module pe_shift_accumulator
    import pe_acc_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] cfg_terms,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] terms_q, terms_d;
    logic [ACC_W-1:0] out_data_d;
    logic             out_valid_d;

    logic             accept;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] terms_new;

    assign in_ready  = (state_q != HOLD) && !clear;
    assign accept    = in_valid && in_ready;
    assign in_ext    = ACC_W'($signed(in_data));
    assign terms_new = (cfg_terms == '0) ? CNT_W'(1) : cfg_terms;

    pe_acc_add #(.W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (in_ext),
        .sum (sum)
    );

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        terms_d     = terms_q;
        out_data_d  = out_data;
        out_valid_d = out_valid;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = in_ext;
                        terms_d = terms_new;
                        cnt_d   = CNT_W'(1);
                        if (terms_new == CNT_W'(1)) begin
                            state_d     = HOLD;
                            out_data_d  = in_ext;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == terms_q - CNT_W'(1)) begin
                            state_d     = HOLD;
                            out_data_d  = sum;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            terms_q   <= CNT_W'(1);
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            terms_q   <= terms_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pe_shift_accumulator.sv
// Directed self-checking bench for pe_shift_accumulator.
// A 24-bit instance covers the main scenarios; a 22-bit instance covers overflow.
module tb_pe_shift_accumulator;
    import pe_acc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [4:0]  cfg_terms;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        busy;

    logic        clear2;
    logic [4:0]  cfg_terms2;
    logic        in_valid2;
    logic        in_ready2;
    logic [19:0] in_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [21:0] out_data2;
    logic        busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_shift_accumulator #(.IN_W(20), .ACC_W(24), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .clear(clear), .cfg_terms(cfg_terms),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    pe_shift_accumulator #(.IN_W(20), .ACC_W(22), .CNT_W(5)) dut22 (
        .clk(clk), .reset(reset), .clear(clear2), .cfg_terms(cfg_terms2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
    );

    task automatic test_reset;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL rst_out_data got %h want 000000", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_rel got %b want 0", busy); end
    endtask

    task automatic test_basic_group;
        logic [19:0] d [4];
        d = '{20'h00003, 20'hFFFFE, 20'h00005, 20'h00001};
        out_ready = 1'b1;
        cfg_terms = 5'(TERMS_4B);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid beat %0d got %b want 0", i, out_valid); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready beat %0d got %b want 1", i, in_ready); end
            in_valid = 1'b1;
            in_data  = d[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 24'd7) begin n_fail++; $display("FAIL basic_out_data got %h want 000007", out_data); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_in_ready got %b want 0", in_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_backpressure;
        cfg_terms = 5'(TERMS_2B);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 20'h00010;
        @(negedge clk);
        in_data  = 20'h00020;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b want 1", k, out_valid); end
            n_checks++; if (out_data !== 24'h000010) begin n_fail++; $display("FAIL bp_data cyc %0d got %h want 000010", k, out_data); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", k, in_ready); end
            if (k == 3) out_ready = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 24'h000020) begin n_fail++; $display("FAIL bp_next_data got %h want 000020", out_data); end
        @(negedge clk);
    endtask

    task automatic test_cfg_zero;
        cfg_terms = 5'd0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 20'hFFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cfg0_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 24'hFFFFFF) begin n_fail++; $display("FAIL cfg0_data got %h want ffffff", out_data); end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [21:0] exp_ovf;
`ifdef PE_ACC_SAT_EN
        exp_ovf = 22'h1FFFFF;
`else
        exp_ovf = 22'h3FFFF8;
`endif
        cfg_terms2 = 5'd8;
        out_ready2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            in_data2  = 20'h7FFFF;
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b want 1", out_valid2); end
        n_checks++; if (out_data2 !== exp_ovf) begin n_fail++; $display("FAIL ovf_data got %h want %h", out_data2, exp_ovf); end
        @(negedge clk);
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL ovf_drop got %b want 0", out_valid2); end
    endtask

    task automatic test_clear_mid_group;
        cfg_terms = 5'(TERMS_4B);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 20'd5;
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %b want 0", out_valid); end
        cfg_terms = 5'(TERMS_2B);
        in_valid  = 1'b1;
        in_data   = 20'd3;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_new_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 24'd3) begin n_fail++; $display("FAIL clr_new_data got %h want 000003", out_data); end
        @(negedge clk);
    endtask

    task automatic test_clear_in_hold;
        cfg_terms = 5'(TERMS_2B);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 20'h00044;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clrh_valid got %b want 1", out_valid); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clrh_drop got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clrh_busy got %b want 0", busy); end
        out_ready = 1'b1;
    endtask

    task automatic test_async_reset;
        cfg_terms = 5'(TERMS_8B);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 20'd7;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy_pre got %b want 1", busy); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", out_valid); end
        @(negedge clk);
        reset     = 1'b1;
        cfg_terms = 5'(TERMS_2B);
        in_valid  = 1'b1;
        in_data   = 20'd9;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_new_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 24'd9) begin n_fail++; $display("FAIL arst_new_data got %h want 000009", out_data); end
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        clear      = 1'b0;
        cfg_terms  = 5'd1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        clear2     = 1'b0;
        cfg_terms2 = 5'd1;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic_group;
        test_backpressure;
        test_cfg_zero;
        test_overflow;
        test_clear_mid_group;
        test_clear_in_hold;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_shift_accumulator.md
Name: pe_shift_accumulator

Overview:
- Downstream consumer of the PE shift stage: receives sign-extended, shifted 20-bit PE partial sums and accumulates a configurable number of them into one multi-precision dot-product result.
- Term count per group comes from the precision mode, e.g. 2b×2b=1, 4b×4b=4, 8b×8b=16.
- Valid/ready handshake on both sides.
- Output is held until the downstream column adder takes it.

Parameters:
- IN_W, 20, width of signed shifted PE sum input
- ACC_W, 24, signed accumulator/output width (ACC_W >= IN_W)
- CNT_W, 5, width of cfg_terms and term counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- clear  input  1  synchronous abort of current group/held result
- cfg_terms  input  CNT_W  terms per group; sampled on first accepted beat of a group; 0 treated as 1
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a beat
- in_data  input  IN_W  signed shifted PE sum
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  ACC_W  signed accumulated result
- busy  output  1  group in progress or result held

Behaviour:
- Reset values (async, reset=0):
  - state=IDLE, acc=0, cnt=0, terms_q=1
  - out_valid=0, out_data=0, busy=0, in_ready=1 after release
- Beat accepted when in_valid && in_ready. All inputs are sign-extended from IN_W to ACC_W.
- IDLE:
  - on accept: acc<=sext(in_data); terms_q<=max(cfg_terms,1); cnt<=1.
  - If terms_q==1: go to HOLD with out_data<=sext(in_data). Otherwise go to ACCUM.
- ACCUM:
  - on accept: acc<=acc+sext(in_data); cnt<=cnt+1.
  - When cnt==terms_q-1 at accept: out_data<=acc+sext(in_data), out_valid<=1, go to HOLD.
  - cfg_terms is ignored in ACCUM.
- HOLD:
  - in_ready=0; out_valid=1; out_data stable.
  - On out_ready: out_valid<=0, acc<=0, cnt<=0, go to IDLE.
  - in_ready returns the following cycle (one bubble per group, by design).
- Latency: out_valid rises the cycle after the last beat is accepted.
- in_ready = (state!=HOLD) && !clear, combinational. Never depends on in_valid.
- clear=1 in any state:
  - next state IDLE; acc=0, cnt=0, out_valid=0.
  - A beat presented with clear is not accepted (in_ready low).
  - clear overrides out_ready in the same cycle.
- Arithmetic: two's complement, wrap-around at ACC_W unless PE_ACC_SAT_EN is defined.
- busy=1 in ACCUM or HOLD.
- Reset mid-group discards the partial sum; no output is produced for that group.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- Defined:
  - every add (including the final one) saturates to ACC_W signed range: max 2^(ACC_W-1)-1, min -2^(ACC_W-1).
  - Once saturated, the value stays clamped until further adds bring it back in range (saturation applied per add).
- Undefined: plain modular wrap at ACC_W bits.

Decomposition:
- Shared package pe_acc_pkg:
  - state enum {IDLE, ACCUM, HOLD}
  - default IN_W/ACC_W/CNT_W constants
  - precision-mode-to-terms constants: TERMS_2B=1, TERMS_4B=4, TERMS_6B=9, TERMS_8B=16
- One natural sub-module: pe_acc_add, the ACC_W signed adder with optional saturation (the PE_ACC_SAT_EN logic lives there). FSM and counter stay in the top.

Test Plan:
- Basic group: cfg_terms=4; beats 0x00003, 0xFFFFE(-2), 0x00005, 0x00001 back-to-back, out_ready=1 → out_data=7 one cycle after 4th beat, out_valid for 1 cycle, in_ready low that cycle.
- Backpressure: single-term group 0x00010, out_ready=0 for 3 cycles → out_valid and out_data=16 held for 4 cycles, in_ready=0 throughout, next beat accepted the cycle after out_ready=1.
- cfg_terms=0: beat 0xFFFFF → treated as 1 term, out_data=-1 (0xFFFFFF at ACC_W=24).
- Overflow (ACC_W=22): 8 beats of 0x7FFFF:
  - PE_ACC_SAT_EN defined → out_data=0x1FFFFF
  - undefined → out_data=0x3FFFF8 (wrapped)
- clear mid-group: cfg_terms=4, 2 beats of 5, then clear with in_valid=1 → beat not accepted. A new 1-term group of 3 → out_data=3.
- Async reset mid-group: reset=0 asynchronously after 2 of 16 beats → out_valid=0, busy=0 immediately. After release, a 1-term group of 9 → out_data=9.
